// File: rtl/bridge_1xn_pkg.sv
// Shared constants and types for the 1-to-N data bridge: default slave windows,
// unmapped read word and the return-pipeline entry layout.
`timescale 1ns/1ps
package bridge_1xn_pkg;
    localparam int XLEN = 32;

    localparam logic [31:0] SRAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] SRAM_MASK    = 32'hFFFF_0000;
    localparam logic [31:0] CONFREG_BASE = 32'h1FAF_0000;
    localparam logic [31:0] CONFREG_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_RDATA_C  = 32'hDEAD_BEEF;

    // Wide enough to index the largest supported slave count (8).
    localparam int IDX_W = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             miss;
        logic             is_read;
    } ret_ent_t;
endpackage

// File: rtl/bridge_addr_dec.sv
// Base/mask address decode with lowest-index priority; purely combinational,
// no backpressure.
`timescale 1ns/1ps
module bridge_addr_dec #(
    parameter int                        XLEN     = 32,
    parameter int                        N_SLAVE  = 4,
    parameter logic [N_SLAVE*XLEN-1:0]   SLV_BASE = '0,
    parameter logic [N_SLAVE*XLEN-1:0]   SLV_MASK = '0
) (
    input  logic                               en,
    input  logic [XLEN-1:0]                    addr,
    output logic [N_SLAVE-1:0]                 sel,
    output logic [bridge_1xn_pkg::IDX_W-1:0]   idx,
    output logic                               miss
);
    localparam int IW = bridge_1xn_pkg::IDX_W;

    logic [N_SLAVE-1:0] hit;

    always_comb begin
        hit = '0;
        sel = '0;
        idx = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            hit[i] = (addr & SLV_MASK[i*XLEN +: XLEN]) ==
                     (SLV_BASE[i*XLEN +: XLEN] & SLV_MASK[i*XLEN +: XLEN]);
        end
        // Walk downwards so the lowest hitting index is the one left standing.
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

    assign miss = en & ~|hit;
endmodule

// File: rtl/bridge_1xn.sv
// Routes one SRAM-style master to N_SLAVE slaves; requests are zero-latency,
// read data returns RD_LATENCY cycles after the strobe; no backpressure.
`timescale 1ns/1ps
module bridge_1xn #(
    parameter int                        XLEN       = bridge_1xn_pkg::XLEN,
    parameter int                        N_SLAVE    = 4,
    parameter logic [N_SLAVE*XLEN-1:0]   SLV_BASE   = '0,
    parameter logic [N_SLAVE*XLEN-1:0]   SLV_MASK   = {N_SLAVE{bridge_1xn_pkg::SRAM_MASK}},
    parameter int                        RD_LATENCY = 1,
    parameter logic [XLEN-1:0]           DEF_RDATA  = bridge_1xn_pkg::DEF_RDATA_C
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_data_en,
    input  logic [3:0]                cpu_data_wen,
    input  logic [XLEN-1:0]           cpu_data_addr,
    input  logic [XLEN-1:0]           cpu_data_wdata,
    output logic [XLEN-1:0]           cpu_data_rdata,
    output logic                      cpu_data_err,
    output logic [N_SLAVE-1:0]        slv_en,
    output logic [4*N_SLAVE-1:0]      slv_wen,
    output logic [XLEN-1:0]           slv_addr,
    output logic [XLEN-1:0]           slv_wdata,
    input  logic [XLEN*N_SLAVE-1:0]   slv_rdata,
    output logic [15:0]               unmapped_cnt
);
    import bridge_1xn_pkg::*;

    if (N_SLAVE < 1 || N_SLAVE > 8) begin : g_bad_nslave
        $error("bridge_1xn: N_SLAVE must be in 1..8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("bridge_1xn: RD_LATENCY must be 1 or 2");
    end

    logic [N_SLAVE-1:0] sel;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_miss;

    bridge_addr_dec #(
        .XLEN     (XLEN),
        .N_SLAVE  (N_SLAVE),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .en   (cpu_data_en),
        .addr (cpu_data_addr),
        .sel  (sel),
        .idx  (dec_idx),
        .miss (dec_miss)
    );

    assign slv_en    = {N_SLAVE{cpu_data_en}} & sel;
    assign slv_addr  = cpu_data_addr;
    assign slv_wdata = cpu_data_wdata;

    for (genvar g = 0; g < N_SLAVE; g++) begin : g_wen
        assign slv_wen[4*g +: 4] = slv_en[g] ? cpu_data_wen : 4'b0000;
    end

    ret_ent_t                  cur;
    ret_ent_t [RD_LATENCY-1:0] pipe;
    ret_ent_t                  tail;
    logic [IDX_W-1:0]          ret_idx;
    logic                      ret_def;

    always_comb begin
        cur         = '0;
        cur.valid   = cpu_data_en;
        cur.idx     = dec_idx;
        cur.miss    = dec_miss;
        cur.is_read = (cpu_data_wen == 4'b0000);
    end

    assign tail = pipe[RD_LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    logic rd_take;
    assign rd_take = tail.valid & tail.is_read;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_idx <= '0;
            ret_def <= 1'b0;
        end else if (rd_take) begin
            ret_idx <= tail.idx;
            ret_def <= tail.miss;
        end
    end

    // The returning entry steers the mux in its own cycle; the held copy keeps
    // the output tracking the same slave until the next read returns.
    logic [IDX_W-1:0] mux_idx;
    logic             mux_def;
    assign mux_idx = rd_take ? tail.idx  : ret_idx;
    assign mux_def = rd_take ? tail.miss : ret_def;

    assign cpu_data_rdata = mux_def ? DEF_RDATA : slv_rdata[int'(mux_idx)*XLEN +: XLEN];
    assign cpu_data_err   = tail.valid & tail.miss;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            unmapped_cnt <= '0;
        end else if (cpu_data_err && unmapped_cnt != 16'hFFFF) begin
            unmapped_cnt <= unmapped_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_bridge_1xn.sv
// Scoreboard bench: a latency-1 bridge with four disjoint windows and a
// latency-2 bridge whose slave 2 overlaps everything, driven in lockstep.
`timescale 1ns/1ps
module tb_bridge_1xn;
    localparam logic [31:0] S0 = 32'h1111_1111;
    localparam logic [31:0] S1 = 32'hAAAA_0001;
    localparam logic [31:0] S2 = 32'hBBBB_0002;
    localparam logic [31:0] S3 = 32'h3333_3333;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [3:0]   wen;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  sd [4];
    logic [127:0] slv_rdata;

    logic [31:0] rdata1, rdata2, saddr1, saddr2, swdata1, swdata2;
    logic        err1, err2;
    logic [3:0]  en1, en2;
    logic [15:0] wen1, wen2, cnt1, cnt2;

    assign slv_rdata = {sd[3], sd[2], sd[1], sd[0]};

    always #5 clk = ~clk;

    bridge_1xn #(
        .XLEN       (32),
        .N_SLAVE    (4),
        .SLV_BASE   ({32'h3000_0000, 32'h2000_0000, 32'h1FAF_0000, 32'h0000_0000}),
        .SLV_MASK   ({4{32'hFFFF_0000}}),
        .RD_LATENCY (1),
        .DEF_RDATA  (32'hDEAD_BEEF)
    ) dut1 (
        .clk(clk), .reset(rst_n), .cpu_data_en(en), .cpu_data_wen(wen),
        .cpu_data_addr(addr), .cpu_data_wdata(wdata), .cpu_data_rdata(rdata1),
        .cpu_data_err(err1), .slv_en(en1), .slv_wen(wen1), .slv_addr(saddr1),
        .slv_wdata(swdata1), .slv_rdata(slv_rdata), .unmapped_cnt(cnt1)
    );

    bridge_1xn #(
        .XLEN       (32),
        .N_SLAVE    (4),
        .SLV_BASE   ({32'h3000_0000, 32'h0000_0000, 32'h1FAF_0000, 32'h0000_0000}),
        .SLV_MASK   ({32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
        .RD_LATENCY (2),
        .DEF_RDATA  (32'hDEAD_BEEF)
    ) dut2 (
        .clk(clk), .reset(rst_n), .cpu_data_en(en), .cpu_data_wen(wen),
        .cpu_data_addr(addr), .cpu_data_wdata(wdata), .cpu_data_rdata(rdata2),
        .cpu_data_err(err2), .slv_en(en2), .slv_wen(wen2), .slv_addr(saddr2),
        .slv_wdata(swdata2), .slv_rdata(slv_rdata), .unmapped_cnt(cnt2)
    );

    typedef struct {
        int          due;
        bit          on_dut2;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_pop();
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                if (sb[i].on_dut2) begin
                    check("rdata_lat2", rdata2, sb[i].rdata);
                end else begin
                    check("rdata_lat1", rdata1, sb[i].rdata);
                    check("err_lat1", {31'b0, err1}, {31'b0, sb[i].err});
                end
            end else if (sb[i].due < cyc) begin
                check("sb_stale_due", sb[i].due, cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] e1,
                         input logic e_err, input logic [31:0] e2, input bit push);
        en    = 1'b1;
        wen   = w;
        addr  = a;
        wdata = $urandom();
        if (push) begin
            sb.push_back('{due: cyc + 1, on_dut2: 1'b0, rdata: e1, err: e_err});
            sb.push_back('{due: cyc + 2, on_dut2: 1'b1, rdata: e2, err: 1'b0});
        end
    endtask

    task automatic go_idle();
        en  = 1'b0;
        wen = 4'b0000;
    endtask

    task automatic half();
        @(negedge clk);
        sb_pop();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            half();
            fin();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        wen   = 4'b0000;
        addr  = 32'h0;
        wdata = 32'h0;
        sd[0] = S0; sd[1] = S1; sd[2] = S2; sd[3] = S3;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_err", {31'b0, err1}, 32'd0);
        check("rst_cnt", {16'b0, cnt1}, 32'd0);
        check("rst_rdata1", rdata1, S0);
        check("rst_rdata2", rdata2, S0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Overlapping windows resolve to slave 0; then back-to-back reads.
        issue(4'b0000, 32'h0000_0020, S0, 1'b0, S0, 1'b1);
        half(); check("ovl_en1", {28'b0, en1}, 32'h1); check("ovl_en2", {28'b0, en2}, 32'h1); fin();
        issue(4'b0000, 32'h1FAF_F000, S1, 1'b0, S1, 1'b1);
        half(); check("b2b_en_a", {28'b0, en1}, 32'h2); fin();
        issue(4'b0000, 32'h2000_0004, S2, 1'b0, S2, 1'b1);
        half(); check("b2b_en_b", {28'b0, en1}, 32'h4); fin();
        go_idle();
        cycles(3);

        // Single read of slave 0, then hold while slave 1 data moves.
        issue(4'b0000, 32'h0000_0010, S0, 1'b0, S0, 1'b1);
        half();
        check("rd_en", {28'b0, en1}, 32'h1);
        check("addr_pass", saddr1, 32'h0000_0010);
        check("wdata_pass", swdata1, wdata);
        check("addr_pass2", saddr2, 32'h0000_0010);
        check("wdata_pass2", swdata2, wdata);
        fin();
        go_idle();
        for (int k = 0; k < 3; k++) begin
            sd[1] = $urandom();
            half();
            check("hold_rdata", rdata1, S0);
            check("hold_err", {31'b0, err1}, 32'd0);
            fin();
        end
        sd[1] = S1;

        // Partial write to slave 3.
        issue(4'b0011, 32'h3000_0000, S0, 1'b0, S0, 1'b1);
        half();
        check("wr_en", {28'b0, en1}, 32'h8);
        check("wr_wen", {16'b0, wen1}, 32'h0000_3000);
        check("wr_wen_ovl", {16'b0, wen2}, 32'h0000_0300);
        fin();
        go_idle();
        cycles(2);

        // Unmapped read, then unmapped write.
        issue(4'b0000, 32'h8000_0000, DEF, 1'b1, S2, 1'b1);
        half(); check("um_rd_en", {28'b0, en1}, 32'h0); fin();
        go_idle();
        cycles(1);
        half();
        check("um_err_once", {31'b0, err1}, 32'd0);
        check("um_cnt1", {16'b0, cnt1}, 32'd1);
        fin();
        issue(4'b1111, 32'h8000_0004, DEF, 1'b1, S2, 1'b1);
        half();
        check("um_wr_en", {28'b0, en1}, 32'h0);
        check("um_wr_wen", {16'b0, wen1}, 32'h0);
        fin();
        go_idle();
        cycles(1);
        half();
        check("um_cnt2", {16'b0, cnt1}, 32'd2);
        check("um_wr_err_once", {31'b0, err1}, 32'd0);
        fin();

        // Reset lands in the return cycle of an unmapped read.
        issue(4'b0000, 32'h8000_0000, DEF, 1'b1, S2, 1'b0);
        half(); fin();
        go_idle();
        rst_n = 1'b0;
        half();
        check("rst_mid_err", {31'b0, err1}, 32'd0);
        fin();
        rst_n = 1'b1;
        cycles(2);
        half();
        check("rst_mid_cnt", {16'b0, cnt1}, 32'd0);
        check("rst_mid_rdata", rdata1, S0);
        fin();

        // Saturation: just below the ceiling, then well past it.
        en   = 1'b1;
        wen  = 4'b0000;
        addr = 32'h8000_0000;
        repeat (65534) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat_below", {16'b0, cnt1}, 32'h0000_FFFE);
        en = 1'b1;
        repeat (5000) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat_cnt", {16'b0, cnt1}, 32'h0000_FFFF);
        check("ovl_no_miss_cnt", {16'b0, cnt2}, 32'd0);
        check("ovl_no_err", {31'b0, err2}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
